id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register for the five-stage RV64 pipeline, sitting directly downstream of the decode-stage control unit. It captures the decoded control bits, operands, immediate and register indices each cycle, and hands them to the execute stage one cycle later. It also turns load-use hazards and branch flushes into bubbles, and counts the bubbles it inserts.

## Interface
- `XLEN`, 64: datapath width for PC, operands and immediate.
- `CNT_W`, 16: width of the bubble counter.

- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  decode slot holds a real instruction.
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm`  in  XLEN each  decoded data fields.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register indices.
- `id_funct4`  in  4  {instr[30], instr[14:12]}, used for ALU control.
- `id_branch`, `id_mem_read`, `id_mem_to_reg`, `id_mem_write`, `id_alu_src`, `id_reg_write`  in  1 each  control-unit outputs.
- `id_alu_op`  in  2  control-unit ALUOp.
- `flush`  in  1  taken branch resolved downstream; kill the instruction in decode.
- `ex_*`  out  same widths as the matching `id_*` inputs  registered copies, including `ex_valid`.
- `hazard_stall`  out  1  combinational; holds PC and IF/ID this cycle.
- `bubble_count`  out  CNT_W  saturating count of inserted bubbles.

## Operation
- Bubble condition: `bubble = flush | hazard_stall`.
- Load-use detection (`raw_hazard`) is true when all of these hold:
  - `ex_valid` and `ex_mem_read` are both 1.
  - `ex_rd` is not 0.
  - `id_valid` is 1.
  - Either `ex_rd == id_rs1`, or `ex_rd == id_rs2` and decode uses rs2.
- Decode uses rs2 when `id_alu_src == 0` (R-type, branch) or when `id_mem_write == 1` (store).
- `hazard_stall = raw_hazard & ~flush`. A flush discards the decode slot, so no stall is needed.
- On every rising edge, outside reset:
  - Data fields (`ex_pc`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm`, `ex_rs1`, `ex_rs2`, `ex_rd`, `ex_funct4`) always load from their `id_*` inputs. Their content is don't-care when `ex_valid` is 0.
  - If `bubble` is 1: `ex_valid` and all control outputs (`ex_branch`, `ex_mem_read`, `ex_mem_to_reg`, `ex_mem_write`, `ex_alu_src`, `ex_reg_write`, `ex_alu_op`) load 0.
  - Otherwise: `ex_valid` loads `id_valid`. Each control output loads its `id_*` input ANDed with `id_valid`, so an invalid slot can never write a register or memory.
- `bubble_count` increments by 1 on each edge where `bubble` is 1. It saturates at all-ones and never wraps.
- An x on `id_mem_to_reg` (store or branch) is captured as-is. It is harmless because `ex_reg_write` is 0 in that case.

## Timing
- Reset (asynchronous, `reset_n` = 0): every `ex_*` output is 0 and `bubble_count` is 0.
  - `hazard_stall` then evaluates to 0 because `ex_valid` is 0.
  - Release is synchronous to the next rising edge.
- Latency: `id_*` to `ex_*` is one cycle.
- `hazard_stall` has zero latency; it is valid in the same cycle as the decode inputs.
- Load-use costs exactly one bubble:
  - Cycle N: load is in EX, dependent instruction is in decode; `hazard_stall` = 1.
  - Cycle N+1: EX holds the bubble (`ex_mem_read` = 0); the stall drops and the dependent instruction, held in decode, enters EX at the N+1 edge.
- Flush and hazard in the same cycle: the flush wins, `hazard_stall` = 0, one bubble is inserted and one count is added.
- Reset asserted mid-pipeline: in-flight contents are discarded immediately, with no partial update.
- `id_rd == 0` from a load never stalls.

## Configuration
- `ID_EX_HAZARD_DETECT_EN` defined: load-use detection as described above.
- `ID_EX_HAZARD_DETECT_EN` undefined:
  - `raw_hazard` is constant 0 and `hazard_stall` is tied 0.
  - Bubbles come only from `flush`.
  - `bubble_count` counts flush cycles only.
  - Forwarding and correct scheduling of load-use pairs are then the software's responsibility.
  - `id_rs1`/`id_rs2` are still registered through to `ex_rs1`/`ex_rs2`.

## Test plan
- Reset: drive random `id_*` with `reset_n` = 0 → all `ex_*` are 0, `bubble_count` = 0, `hazard_stall` = 0. After release, one `add x3,x1,x2` (`id_reg_write` = 1, `id_alu_op` = 10) → `ex_valid` = 1, `ex_reg_write` = 1, `ex_alu_op` = 10, `ex_rd` = 3 one edge later.
- Load-use: `ld x5,0(x1)` followed by `add x6,x5,x2` → `hazard_stall` = 1 for exactly one cycle, EX holds a bubble (all control bits 0), the add reaches EX the next edge, `bubble_count` = 1.
- Non-hazards:
  - `ld x0` followed by `add x6,x0,x2` → no stall.
  - `ld x5` followed by `addi x6,x7,4` with `id_rs2` = 5 and `id_alu_src` = 1 → no stall.
  - `ld x5` followed by `sd x5,0(x8)` (rs2 = 5, `id_mem_write` = 1) → stall.
- Flush priority: assert `flush` while a load-use hazard is present → `hazard_stall` = 0, one bubble inserted, `bubble_count` increments by exactly 1.
- Saturation: preload `bubble_count` to 0xFFFE, then assert `flush` for 3 cycles → count reads 0xFFFF and holds.
- Build without `ID_EX_HAZARD_DETECT_EN`: rerun the load-use scenario → `hazard_stall` stays 0, the add enters EX directly behind the load, `bubble_count` = 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode outputs, inserts bubbles on flush or load-use, counts bubbles.
// Optional load-use detection is enabled by defining ID_EX_HAZARD_DETECT_EN.
module id_ex_stage #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             id_valid,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic [3:0]       id_funct4,
   input  logic             id_branch,
   input  logic             id_mem_read,
   input  logic             id_mem_to_reg,
   input  logic             id_mem_write,
   input  logic             id_alu_src,
   input  logic             id_reg_write,
   input  logic [1:0]       id_alu_op,
   input  logic             flush,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rs1_data,
   output logic [XLEN-1:0]  ex_rs2_data,
   output logic [XLEN-1:0]  ex_imm,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic [3:0]       ex_funct4,
   output logic             ex_branch,
   output logic             ex_mem_read,
   output logic             ex_mem_to_reg,
   output logic             ex_mem_write,
   output logic             ex_alu_src,
   output logic             ex_reg_write,
   output logic [1:0]       ex_alu_op,
   output logic             hazard_stall,
   output logic [CNT_W-1:0] bubble_count
);

   logic raw_hazard_s;
   logic bubble_s;

`ifdef ID_EX_HAZARD_DETECT_EN
   logic uses_rs2_s;

   // Load-use detection: a load in EX whose destination is read by the instruction in decode.
   always_comb begin
      uses_rs2_s   = ~id_alu_src | id_mem_write;
      raw_hazard_s = 1'b0;
      if (ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
          ((ex_rd == id_rs1) || ((ex_rd == id_rs2) && uses_rs2_s))) begin
         raw_hazard_s = 1'b1;
      end else begin
         raw_hazard_s = 1'b0;
      end
   end
`else
   // Without detection, load-use scheduling is left to software.
   always_comb begin
      raw_hazard_s = 1'b0;
   end
`endif

   // A flush discards the decode slot anyway, so it suppresses the stall.
   assign hazard_stall = raw_hazard_s & ~flush;
   assign bubble_s     = flush | hazard_stall;

   // Data fields follow decode every cycle; they are meaningless while ex_valid is 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_pc       <= {XLEN{1'b0}};
         ex_rs1_data <= {XLEN{1'b0}};
         ex_rs2_data <= {XLEN{1'b0}};
         ex_imm      <= {XLEN{1'b0}};
         ex_rs1      <= 5'd0;
         ex_rs2      <= 5'd0;
         ex_rd       <= 5'd0;
         ex_funct4   <= 4'd0;
      end else begin
         ex_pc       <= id_pc;
         ex_rs1_data <= id_rs1_data;
         ex_rs2_data <= id_rs2_data;
         ex_imm      <= id_imm;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
         ex_rd       <= id_rd;
         ex_funct4   <= id_funct4;
      end
   end

   // Valid and control bits: zeroed on a bubble, gated by id_valid otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_valid      <= 1'b0;
         ex_branch     <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_alu_src    <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_alu_op     <= 2'b00;
      end else if (bubble_s) begin
         ex_valid      <= 1'b0;
         ex_branch     <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_alu_src    <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_alu_op     <= 2'b00;
      end else begin
         ex_valid      <= id_valid;
         ex_branch     <= id_branch & id_valid;
         ex_mem_read   <= id_mem_read & id_valid;
         ex_mem_to_reg <= id_mem_to_reg & id_valid;
         ex_mem_write  <= id_mem_write & id_valid;
         ex_alu_src    <= id_alu_src & id_valid;
         ex_reg_write  <= id_reg_write & id_valid;
         ex_alu_op     <= id_alu_op & {2{id_valid}};
      end
   end

   // Saturating bubble counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bubble_count <= {CNT_W{1'b0}};
      end else if (bubble_s && (bubble_count != {CNT_W{1'b1}})) begin
         bubble_count <= bubble_count + CNT_W'(1);
      end else begin
         bubble_count <= bubble_count;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: random and directed stimulus against a behavioural model.
module tb_id_ex_stage;

`ifdef ID_EX_HAZARD_DETECT_EN
   localparam bit HAZ_EN = 1'b1;
`else
   localparam bit HAZ_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   logic id_valid, flush;
   logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic [3:0] id_funct4;
   logic id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write;
   logic [1:0] id_alu_op;
   logic ex_valid;
   logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0] ex_rs1, ex_rs2, ex_rd;
   logic [3:0] ex_funct4;
   logic ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
   logic [1:0] ex_alu_op;
   logic hazard_stall;
   logic [15:0] bubble_count;

   int checks = 0;
   int errors = 0;

   // behavioural model of what EX should hold
   logic m_valid;
   logic [63:0] m_pc, m_rs1d, m_rs2d, m_imm;
   logic [4:0] m_rs1, m_rs2, m_rd;
   logic [3:0] m_f4;
   logic m_br, m_mr, m_m2r, m_mw, m_as, m_rw;
   logic [1:0] m_aop;
   logic [15:0] m_cnt;
   logic last_stall;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(64), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
      .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct4(id_funct4),
      .id_branch(id_branch), .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg),
      .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
      .id_alu_op(id_alu_op), .flush(flush),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct4(ex_funct4),
      .ex_branch(ex_branch), .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
      .ex_alu_op(ex_alu_op), .hazard_stall(hazard_stall), .bubble_count(bubble_count)
   );

   task automatic model_reset();
      {m_valid, m_pc, m_rs1d, m_rs2d, m_imm, m_rs1, m_rs2, m_rd, m_f4} = '0;
      {m_br, m_mr, m_m2r, m_mw, m_as, m_rw, m_aop} = '0;
      m_cnt = 16'd0;
   endtask

   // "Load in EX writes a register the decode instruction reads" under the rs2-usage rule.
   function automatic bit model_hazard();
      bit reads_rs2 = !id_alu_src || id_mem_write;
      bit depends   = (id_rs1 == m_rd) || (reads_rs2 && (id_rs2 == m_rd));
      return HAZ_EN && m_valid && m_mr && (m_rd != 5'd0) && id_valid && depends;
   endfunction

   task automatic model_step(input bit stall);
      bit bubble = flush || stall;
      bit keep   = !bubble && id_valid;
      m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_f4 = id_funct4;
      m_valid = keep;
      m_br = keep ? id_branch : 1'b0;
      m_mr = keep ? id_mem_read : 1'b0;
      m_m2r = keep ? id_mem_to_reg : 1'b0;
      m_mw = keep ? id_mem_write : 1'b0;
      m_as = keep ? id_alu_src : 1'b0;
      m_rw = keep ? id_reg_write : 1'b0;
      m_aop = keep ? id_alu_op : 2'b00;
      if (bubble && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
   endtask

   task automatic rand_data();
      id_pc = {$urandom, $urandom}; id_rs1_data = {$urandom, $urandom};
      id_rs2_data = {$urandom, $urandom}; id_imm = {$urandom, $urandom};
      id_funct4 = 4'($urandom);
   endtask

   task automatic set_instr(input bit v, input int rs1, input int rs2, input int rd,
                            input bit br, input bit mr, input bit m2r, input bit mw,
                            input bit as, input bit rw, input logic [1:0] aop);
      rand_data();
      id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
      id_branch = br; id_mem_read = mr; id_mem_to_reg = m2r; id_mem_write = mw;
      id_alu_src = as; id_reg_write = rw; id_alu_op = aop;
   endtask

   task automatic rand_instr();
      rand_data();
      id_valid = 1'($urandom); id_rs1 = 5'($urandom_range(0, 7));
      id_rs2 = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
      {id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write} = 6'($urandom);
      id_alu_op = 2'($urandom);
   endtask

   // One clock: check the combinational stall, step the model, check registered outputs.
   task automatic cycle(input string name);
      logic [283:0] act, exp;
      bit exp_stall;
      #1;
      exp_stall = model_hazard() && !flush;
      last_stall = hazard_stall;
      checks++;
      if (hazard_stall !== exp_stall) begin
         errors++;
         $display("FAIL %s stall: got %b expected %b", name, hazard_stall, exp_stall);
      end
      model_step(exp_stall);
      @(posedge clk);
      @(negedge clk);
      act = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct4,
             ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op};
      exp = {m_valid, m_pc, m_rs1d, m_rs2d, m_imm, m_rs1, m_rs2, m_rd, m_f4,
             m_br, m_mr, m_m2r, m_mw, m_as, m_rw, m_aop};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s ex: got %h expected %h", name, act, exp);
      end
      checks++;
      if (bubble_count !== m_cnt) begin
         errors++;
         $display("FAIL %s count: got %h expected %h", name, bubble_count, m_cnt);
      end
   endtask

   task automatic check_zero(input string name);
      logic [283:0] act;
      act = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct4,
             ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op};
      checks++;
      if (act !== '0 || bubble_count !== 16'd0 || hazard_stall !== 1'b0) begin
         errors++;
         $display("FAIL %s: got ex=%h cnt=%h stall=%b expected all 0", name, act, bubble_count, hazard_stall);
      end
   endtask

   task automatic nop();
      set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      flush = 1'b0;
      cycle("nop");
   endtask

   task automatic test_reset();
      reset_n = 1'b0; flush = 1'($urandom);
      rand_instr();
      @(posedge clk); #2;
      check_zero("reset");
      model_reset();
      @(negedge clk);
      reset_n = 1'b1; flush = 1'b0;
      set_instr(1, 1, 2, 3, 0, 0, 0, 0, 0, 1, 2'b10);
      cycle("add_x3");
      checks++;
      if ({ex_valid, ex_reg_write, ex_alu_op, ex_rd} !== {1'b1, 1'b1, 2'b10, 5'd3}) begin
         errors++;
         $display("FAIL add_x3 fields: got %b %b %b %0d expected 1 1 10 3",
                  ex_valid, ex_reg_write, ex_alu_op, ex_rd);
      end
   endtask

   task automatic test_load_use();
      logic [15:0] cnt0;
      nop();
      cnt0 = m_cnt;
      set_instr(1, 1, 0, 5, 0, 1, 1, 0, 1, 1, 2'b00);
      cycle("ld_x5");
      set_instr(1, 5, 2, 6, 0, 0, 0, 0, 0, 1, 2'b10);
      cycle("add_dep");
      checks++;
      if (last_stall !== HAZ_EN || ex_valid !== !HAZ_EN || ex_mem_read !== 1'b0) begin
         errors++;
         $display("FAIL load_use bubble: got stall=%b valid=%b mr=%b expected %b %b 0",
                  last_stall, ex_valid, ex_mem_read, HAZ_EN, !HAZ_EN);
      end
      cycle("add_held");
      checks++;
      if (last_stall !== 1'b0 || ex_valid !== 1'b1 || ex_rd !== 5'd6 ||
          bubble_count !== cnt0 + 16'(HAZ_EN)) begin
         errors++;
         $display("FAIL load_use enter: got stall=%b valid=%b rd=%0d cnt=%0d expected 0 1 6 %0d",
                  last_stall, ex_valid, ex_rd, bubble_count, cnt0 + 16'(HAZ_EN));
      end
   endtask

   task automatic test_non_hazard();
      // ld x0 then add x6,x0,x2
      nop();
      set_instr(1, 1, 0, 0, 0, 1, 1, 0, 1, 1, 2'b00);
      cycle("ld_x0");
      set_instr(1, 0, 2, 6, 0, 0, 0, 0, 0, 1, 2'b10);
      cycle("add_x0");
      checks++;
      if (last_stall !== 1'b0) begin
         errors++;
         $display("FAIL ld_x0 stall: got %b expected 0", last_stall);
      end
      // ld x5 then addi x6,x7,4 with rs2 field 5
      nop();
      set_instr(1, 1, 0, 5, 0, 1, 1, 0, 1, 1, 2'b00);
      cycle("ld_x5b");
      set_instr(1, 7, 5, 6, 0, 0, 0, 0, 1, 1, 2'b00);
      cycle("addi");
      checks++;
      if (last_stall !== 1'b0) begin
         errors++;
         $display("FAIL addi stall: got %b expected 0", last_stall);
      end
      // ld x5 then sd x5,0(x8)
      nop();
      set_instr(1, 1, 0, 5, 0, 1, 1, 0, 1, 1, 2'b00);
      cycle("ld_x5c");
      set_instr(1, 8, 5, 0, 0, 0, 0, 1, 1, 0, 2'b00);
      cycle("sd");
      checks++;
      if (last_stall !== HAZ_EN) begin
         errors++;
         $display("FAIL sd stall: got %b expected %b", last_stall, HAZ_EN);
      end
      cycle("sd_held");
   endtask

   task automatic test_flush_priority();
      logic [15:0] cnt0;
      nop();
      set_instr(1, 1, 0, 5, 0, 1, 1, 0, 1, 1, 2'b00);
      cycle("ld_fl");
      cnt0 = m_cnt;
      set_instr(1, 5, 2, 6, 0, 0, 0, 0, 0, 1, 2'b10);
      flush = 1'b1;
      cycle("flush_haz");
      checks++;
      if (last_stall !== 1'b0 || ex_valid !== 1'b0 || bubble_count !== cnt0 + 16'd1) begin
         errors++;
         $display("FAIL flush_prio: got stall=%b valid=%b cnt=%0d expected 0 0 %0d",
                  last_stall, ex_valid, bubble_count, cnt0 + 16'd1);
      end
      flush = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rand_instr();
         flush = ($urandom_range(0, 7) == 0);
         cycle("random");
      end
      flush = 1'b0;
   endtask

   task automatic test_midreset();
      rand_instr(); flush = 1'b0; id_valid = 1'b1;
      cycle("pre_rst");
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      check_zero("mid_reset");
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      cycle("post_rst");
   endtask

   task automatic test_saturation();
      reset_n = 1'b0; #1; model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      rand_instr(); flush = 1'b1;
      repeat (65534) begin
         model_step(1'b0);
         @(negedge clk);
      end
      checks++;
      if (bubble_count !== 16'hFFFE) begin
         errors++;
         $display("FAIL preload: got %h expected fffe", bubble_count);
      end
      for (int i = 0; i < 3; i++) cycle("saturate");
      checks++;
      if (bubble_count !== 16'hFFFF) begin
         errors++;
         $display("FAIL saturate: got %h expected ffff", bubble_count);
      end
      flush = 1'b0;
   endtask

   initial begin
      model_reset();
      last_stall = 1'b0;
      test_reset();
      test_load_use();
      test_non_hazard();
      test_flush_priority();
      test_random();
      test_midreset();
      test_load_use();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
